// File: rtl/video_scan_doubler_pkg.sv
// Shared defaults and helpers for the scan doubler: line geometry, sync polarities
// and the pixel colour type.
package video_scan_doubler_pkg;

    localparam int   DEF_ADDR_W       = 10;
    localparam int   DEF_IN_H_START   = 192;
    localparam int   DEF_H_ACTIVE     = 640;
    localparam int   DEF_OUT_H_START  = 144;
    localparam int   DEF_OUT_HS_WIDTH = 96;
    localparam logic DEF_HS_POL       = 1'b0;
    localparam logic DEF_VS_POL       = 1'b0;

    typedef logic [2:0] rgb_t;

    // True when a pixel counter lies inside [start, start+len).
    function automatic logic in_window(input int cnt, input int start, input int len);
        return (cnt >= start) && (cnt < start + len);
    endfunction

endpackage

// File: rtl/video_scan_doubler_line_buffer_dp.sv
// Simple dual-port line buffer: one synchronous write port, one read port with a
// registered output. The address MSB selects the ping-pong bank.
module line_buffer_dp #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 3
) (
    input  logic              CLK,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately left unreset so the array maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/video_scan_doubler.sv
// Line doubler: captures each 15.6 kHz input line into one bank of a ping-pong
// buffer and replays the previous line twice at double pixel rate with fresh syncs.
module video_scan_doubler
    import video_scan_doubler_pkg::*;
#(
    parameter int   ADDR_W       = DEF_ADDR_W,
    parameter int   IN_H_START   = DEF_IN_H_START,
    parameter int   H_ACTIVE     = DEF_H_ACTIVE,
    parameter int   OUT_H_START  = DEF_OUT_H_START,
    parameter int   OUT_HS_WIDTH = DEF_OUT_HS_WIDTH,
    parameter logic HS_POL       = DEF_HS_POL,
    parameter logic VS_POL       = DEF_VS_POL
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic IN_PIX_en,
    input  logic OUT_PIX_en,
    input  logic HSYNC,
    input  logic VSYNC,
    input  rgb_t RGB,
    output logic VGA_HSYNC,
    output logic VGA_VSYNC,
    output rgb_t VGA_RGB
);

    localparam logic [ADDR_W-1:0] CNT_MAX   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] IN_OFS    = ADDR_W'(IN_H_START);
    localparam logic [ADDR_W-1:0] OUT_OFS   = ADDR_W'(OUT_H_START);
    localparam logic [1:0]        VALID_MAX = 2'd2;

    logic              hs_q, hs_dly_q, hs_rise;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic [1:0]        valid_cnt_q, valid_cnt_d;
    logic              vga_hs_q, vga_hs_d;
    logic              vga_vs_q, vga_vs_d;
    logic              active_q, active_d;

    logic              we;
    logic [ADDR_W:0]   waddr, raddr;
    rgb_t              rdata;

    assign hs_rise = hs_q & ~hs_dly_q;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            hs_q        <= 1'b0;
            hs_dly_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            valid_cnt_q <= '0;
            vga_hs_q    <= ~HS_POL;
            vga_vs_q    <= ~VS_POL;
            active_q    <= 1'b0;
        end else begin
            hs_q        <= HSYNC;
            hs_dly_q    <= hs_q;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            valid_cnt_q <= valid_cnt_d;
            vga_hs_q    <= vga_hs_d;
            vga_vs_q    <= vga_vs_d;
            active_q    <= active_d;
        end
    end

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_bank_d   = wr_bank_q;
        valid_cnt_d = valid_cnt_q;
        vga_hs_d    = vga_hs_q;
        vga_vs_d    = vga_vs_q;
        active_d    = active_q;

        if (hs_rise) begin
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            wr_bank_d = ~wr_bank_q;
            if (valid_cnt_q != VALID_MAX) begin
                valid_cnt_d = valid_cnt_q + 2'd1;
            end
        end else begin
            if (IN_PIX_en && (wr_cnt_q != CNT_MAX)) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
            // Natural wrap at LINE_LEN starts the second output copy of the line.
            if (OUT_PIX_en) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end

        // Sync and active flag move with the RAM read so all three outputs align.
        if (OUT_PIX_en) begin
            vga_hs_d = (int'(rd_cnt_q) < OUT_HS_WIDTH) ? HS_POL : ~HS_POL;
            active_d = in_window(int'(rd_cnt_q), OUT_H_START, H_ACTIVE)
                       && (valid_cnt_q == VALID_MAX);
            if (rd_cnt_q == '0) begin
                vga_vs_d = VSYNC ? VS_POL : ~VS_POL;
            end
        end
    end

    assign we    = IN_PIX_en && in_window(int'(wr_cnt_q), IN_H_START, H_ACTIVE);
    assign waddr = {wr_bank_q, wr_cnt_q - IN_OFS};
    assign raddr = {~wr_bank_q, rd_cnt_q - OUT_OFS};

    line_buffer_dp #(
        .ADDR_W (ADDR_W + 1),
        .DATA_W ($bits(rgb_t))
    ) u_line_buffer (
        .CLK     (CLK),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (RGB),
        .rd_en_i (OUT_PIX_en),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign VGA_HSYNC = vga_hs_q;
    assign VGA_VSYNC = vga_vs_q;
    assign VGA_RGB   = active_q ? rdata : '0;

endmodule

// File: tb/tb_video_scan_doubler.sv
// Directed bench for the scan doubler: one input line per call, outputs captured per
// CLK and compared against hand-derived line timing and pixel patterns.
`timescale 1ns/1ps
module tb_video_scan_doubler;

    logic       CLK = 1'b0;
    logic       nRESET, IN_PIX_en, OUT_PIX_en, HSYNC, VSYNC;
    logic [2:0] RGB;
    logic       VGA_HSYNC, VGA_VSYNC;
    logic [2:0] VGA_RGB;

    int tests_run    = 0;
    int tests_failed = 0;

    logic       cap_hs  [8192];
    logic       cap_vs  [8192];
    logic [2:0] cap_rgb [8192];

    always #5 CLK = ~CLK;

    video_scan_doubler dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .IN_PIX_en  (IN_PIX_en),
        .OUT_PIX_en (OUT_PIX_en),
        .HSYNC      (HSYNC),
        .VSYNC      (VSYNC),
        .RGB        (RGB),
        .VGA_HSYNC  (VGA_HSYNC),
        .VGA_VSYNC  (VGA_VSYNC),
        .VGA_RGB    (VGA_RGB)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Pixel pattern that differs under any small address offset.
    function automatic logic [2:0] pat(input int seed, input int k);
        int v;
        v = k ^ (k >> 3) ^ (k >> 6) ^ (seed * 3);
        return v[2:0];
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            HSYNC     = 1'b0;
            IN_PIX_en = i[0];
            @(posedge CLK);
            #1;
        end
    endtask

    // HSYNC rises at q=0; the doubler sees it at edge q=1. Input strobes land on odd
    // edges, the strobe at q=2j+1 carries input pixel k=j-1-192.
    task automatic run_line(input int len, input int seed, input int vs_q, input logic vs_val);
        for (int q = 0; q < len; q++) begin
            int j, k;
            j          = (q - 1) / 2;
            k          = j - 1 - 192;
            HSYNC      = (q < 8);
            IN_PIX_en  = q[0];
            OUT_PIX_en = 1'b1;
            RGB        = (q[0] && k >= 0 && k < 640) ? pat(seed, k) : 3'b111;
            if (q == vs_q) VSYNC = vs_val;
            @(posedge CLK);
            #1;
            cap_hs[q]  = VGA_HSYNC;
            cap_vs[q]  = VGA_VSYNC;
            cap_rgb[q] = VGA_RGB;
        end
    endtask

    // Output sampled after edge q shows output count r=(q-2) mod 1024.
    // Pixels k<=split use seed_lo, k>split+1 use seed_hi, k==split+1 is not checked.
    task automatic check_line(input string tag, input int len, input bit valid,
                              input int seed_lo, input int seed_hi, input int split,
                              input int exp_low);
        int hs_err  = 0;
        int rgb_err = 0;
        int low     = 0;
        for (int q = 2; q < len; q++) begin
            int         r, k;
            logic       exp_hs;
            logic [2:0] exp_rgb;
            bit         skip;
            r       = (q - 2) % 1024;
            exp_hs  = (r < 96) ? 1'b0 : 1'b1;
            exp_rgb = 3'b000;
            skip    = 1'b0;
            if (valid && r >= 144 && r < 784) begin
                k = r - 144;
                if (k <= split)          exp_rgb = pat(seed_lo, k);
                else if (k == split + 1) skip = 1'b1;
                else                     exp_rgb = pat(seed_hi, k);
            end
            if (cap_hs[q] !== exp_hs) hs_err++;
            if (cap_hs[q] == 1'b0) low++;
            if (!skip && cap_rgb[q] !== exp_rgb) rgb_err++;
        end
        check({tag, "_hs_errs"}, hs_err, 0);
        check({tag, "_rgb_errs"}, rgb_err, 0);
        check({tag, "_hs_low_cycles"}, low, exp_low);
    endtask

    function automatic int first_vs(input logic val, input int len);
        for (int q = 0; q < len; q++) begin
            if (cap_vs[q] == val) return q;
        end
        return -1;
    endfunction

    function automatic int vs_glitches(input logic val, input int from, input int len);
        int n = 0;
        for (int q = from; q < len; q++) begin
            if (cap_vs[q] != val) n++;
        end
        return n;
    endfunction

    initial begin
        nRESET     = 1'b0;
        IN_PIX_en  = 1'b0;
        OUT_PIX_en = 1'b1;
        HSYNC      = 1'b0;
        VSYNC      = 1'b0;
        RGB        = 3'b000;
        for (int i = 0; i < 3; i++) begin
            IN_PIX_en = i[0];
            @(posedge CLK);
            #1;
        end
        check("rst_vga_hsync", VGA_HSYNC, 1);
        check("rst_vga_vsync", VGA_VSYNC, 1);
        check("rst_vga_rgb", VGA_RGB, 0);
        $display("[TB] reset: hs=%0d vs=%0d rgb=%0d", VGA_HSYNC, VGA_VSYNC, VGA_RGB);
        nRESET = 1'b1;
        idle(20);

        run_line(2048, 1, -1, 1'b0);
        check_line("lineA_black", 2048, 1'b0, 0, 0, 1000, 192);
        $display("[TB] line A: first capture, output black");

        run_line(2048, 2, -1, 1'b0);
        check_line("lineB", 2048, 1'b1, 1, 1, 1000, 192);
        check("B_px0", cap_rgb[146], pat(1, 0));
        check("B_before_active", cap_rgb[145], 0);
        check("B_px639", cap_rgb[785], pat(1, 639));
        check("B_after_active", cap_rgb[786], 0);
        check("B_second_copy_px0", cap_rgb[1170], pat(1, 0));
        $display("[TB] line B: replay of line A twice");

        run_line(2048, 3, 500, 1'b1);
        check_line("lineC", 2048, 1'b1, 2, 2, 1000, 192);
        check("C_vsync_fall_pos", first_vs(1'b0, 2048), 1026);
        check("C_vsync_stable", vs_glitches(1'b0, 1026, 2048), 0);
        $display("[TB] line C: VSYNC raised mid-line");

        run_line(2048, 4, 300, 1'b0);
        check_line("lineD", 2048, 1'b1, 3, 3, 1000, 192);
        check("D_vsync_rise_pos", first_vs(1'b1, 2048), 1026);
        $display("[TB] line D: VSYNC dropped mid-line");

        run_line(1400, 5, -1, 1'b0);
        check_line("lineE_short", 1400, 1'b1, 4, 4, 1000, 192);
        $display("[TB] line E: short line of 700 input pixels");

        run_line(2048, 6, -1, 1'b0);
        check_line("lineF_after_short", 2048, 1'b1, 5, 3, 506, 192);
        $display("[TB] line F: partial new capture over older bank data");

        run_line(8192, 7, -1, 1'b0);
        check_line("lineG_freerun", 8192, 1'b1, 6, 6, 1000, 768);
        $display("[TB] line G: HSYNC absent for 4 line periods");

        run_line(2048, 8, -1, 1'b0);
        check_line("lineH_after_long", 2048, 1'b1, 7, 7, 1000, 192);
        $display("[TB] line H: replay of saturated long line");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/video_scan_doubler.md
Name: video_scan_doubler

Overview:
- Line-doubling converter downstream of the display controller's RGB/HSYNC/VSYNC outputs.
- Captures each 15.6 kHz input scanline into one bank of a ping-pong line buffer.
- Replays the previous line twice at double pixel rate, giving VGA-compatible 31.25 kHz output with regenerated HSYNC and line-aligned VSYNC.
- Sits between the display controller and the board's VGA DAC pins.

Parameters:
- ADDR_W, 10, line-buffer address width; LINE_LEN = 2**ADDR_W pixel slots per line.
- IN_H_START, 192, input pixel count after input HSYNC rising edge at which capture begins.
- H_ACTIVE, 640, pixels captured per line and replayed per output line; must satisfy IN_H_START+H_ACTIVE <= LINE_LEN.
- OUT_H_START, 144, output pixel count at which replay begins; must satisfy OUT_H_START+H_ACTIVE <= LINE_LEN.
- OUT_HS_WIDTH, 96, output HSYNC width in output pixels.
- HS_POL, 0, output HSYNC active level.
- VS_POL, 0, output VSYNC active level.

Ports:
- CLK  in  1  system clock.
- nRESET  in  1  synchronous active-low reset.
- IN_PIX_en  in  1  input pixel strobe, 16 MHz rate.
- OUT_PIX_en  in  1  output pixel strobe, exactly 2x IN_PIX_en rate.
- HSYNC  in  1  input horizontal sync, active high.
- VSYNC  in  1  input vertical sync, active high.
- RGB  in  3  input pixel colour.
- VGA_HSYNC  out  1  output horizontal sync, polarity HS_POL.
- VGA_VSYNC  out  1  output vertical sync, polarity VS_POL.
- VGA_RGB  out  3  output pixel colour.

Behaviour:
- Reset (CLK edge with nRESET=0): wr_cnt=0, rd_cnt=0, wr_bank=0, valid_cnt=0. VGA_HSYNC=~HS_POL, VGA_VSYNC=~VS_POL, VGA_RGB=0. Buffer contents are not reset.
- HSYNC edge detect: HSYNC is registered every CLK; a rising edge (hs_rise) is seen one CLK after HSYNC rises.
- On hs_rise:
  - wr_cnt<=0 and wr_bank<=~wr_bank.
  - rd_cnt<=0.
  - valid_cnt increments, saturating at 2.
  - Takes priority over any simultaneous strobe-driven counter update.
- Write side: on IN_PIX_en, wr_cnt increments, saturating at LINE_LEN-1.
  - RGB is written to address {wr_bank, wr_cnt-IN_H_START} when IN_H_START <= wr_cnt < IN_H_START+H_ACTIVE.
  - No write otherwise.
- Read side: reads from bank ~wr_bank, i.e. the line completed before the latest hs_rise.
  - On OUT_PIX_en, rd_cnt increments modulo LINE_LEN; it wraps naturally once mid input line, producing the second output line.
- Free-run: if no hs_rise arrives, rd_cnt keeps wrapping and the same bank is replayed indefinitely.
- Read address is rd_cnt-OUT_H_START. Buffer read is registered, so RGB appears one OUT_PIX_en later.
  - VGA_HSYNC and the active flag are delayed by the same single OUT_PIX_en stage, keeping all three aligned.
- VGA_HSYNC is active while the delayed rd_cnt < OUT_HS_WIDTH.
- VGA_RGB equals buffer data while OUT_H_START <= delayed rd_cnt < OUT_H_START+H_ACTIVE and valid_cnt==2; otherwise 3'b000.
- VGA_VSYNC: input VSYNC is sampled into VGA_VSYNC (polarity-mapped) only on OUT_PIX_en with rd_cnt==0, so VSYNC transitions only at output line starts.
- Early input HSYNC (short line): rd_cnt restarts immediately and the current output line is truncated. No error state.
- Late input HSYNC (long line): write saturates and the extra pixels are dropped.
- Reset mid-line: all state returns to reset values within one CLK. Output stays black until two further hs_rise events.
- Read and write never target the same bank simultaneously, so no collision logic is needed.

Decomposition:
- Shared video package holds the defaults: ADDR_W, IN_H_START, H_ACTIVE, OUT_H_START, OUT_HS_WIDTH, and the sync polarity constants.
- One sub-module, line_buffer_dp: simple dual-port RAM, 2*LINE_LEN x 3.
  - Synchronous write port: we, waddr.
  - Synchronous read port: raddr, registered rdata, rd_en.
  - Bank bit is the address MSB.
  - Intended to infer block RAM.

Test Plan:
- Reset: nRESET low 3 cycles, strobes running -> VGA_HSYNC=1, VGA_VSYNC=1 (polarity 0), VGA_RGB=0. VGA_RGB stays 0 until the second hs_rise.
- Single line replay: input line with RGB=pixel_index[2:0] from count 192, HSYNC period 1024 IN_PIX_en.
  - Next input line yields two output lines, each 1024 OUT_PIX_en long.
  - Pixel k (k=0..639) equals k[2:0] at output count 144+k+1 strobe.
- Sync timing: VGA_HSYNC low for exactly 96 OUT_PIX_en per output line, at rd_cnt 0 and at the 1024 wrap. Two pulses per input line.
- VSYNC alignment: input VSYNC raised mid-line -> VGA_VSYNC falls at the next rd_cnt==0 strobe, never mid-line.
- Short line: input HSYNC after 700 IN_PIX_en -> rd_cnt restarts at 0, bank swaps, and the next output line shows the newly captured data.
- Free-run: HSYNC held low for 4 line periods -> same line data repeats every 1024 OUT_PIX_en, with no write to the read bank.
